// File: rtl/stream_pkg.sv
// Shared helpers for multi-lane AXI-Stream blocks: total bus width and lane
// offsets, so every block slices lanes the same way.
package stream_pkg;

    function automatic int total_width(input int s_count, input int data_width);
        return s_count * data_width;
    endfunction

    // Lane i occupies bits [lane_lsb(i, dw) +: dw].
    function automatic int lane_lsb(input int idx, input int data_width);
        return idx * data_width;
    endfunction

endpackage

// File: rtl/skid_reg.sv
// One-entry skid stage: output register plus a temp register. The ready it
// reports is a flop, so there is no combinational path from out_ready to in_ready.
module skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             room_q;
    logic             out_valid_q;
    logic             tmp_valid_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] tmp_q;
    logic             accept;
    logic             out_free;

    assign accept   = room_q & in_valid;
    assign out_free = ~out_valid_q | out_ready;

    // Room is only promised when the next cycle can absorb a beat even if the
    // output stalls: temp is never written while it already holds a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            room_q      <= 1'b0;
            out_valid_q <= 1'b0;
            tmp_valid_q <= 1'b0;
        end else begin
            room_q <= out_free | (~tmp_valid_q & (~out_valid_q | ~in_valid));
            if (out_free) begin
                if (tmp_valid_q) begin
                    out_valid_q <= 1'b1;
                    tmp_valid_q <= accept;
                end else begin
                    out_valid_q <= accept;
                end
            end else if (accept) begin
                tmp_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (out_free) begin
            if (tmp_valid_q) begin
                out_q <= tmp_q;
            end else if (accept) begin
                out_q <= in_data;
            end
            if (tmp_valid_q && accept) begin
                tmp_q <= in_data;
            end
        end else if (accept) begin
            tmp_q <= in_data;
        end
    end

    assign in_ready  = room_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/gather.sv
// Gathers S_COUNT AXI-Stream lanes into one wide beat; all lanes move together.
// Define GATHER_SKID_EN for a skid-buffered (registered-ready) version.
module gather
    import stream_pkg::*;
#(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    output logic [S_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int W = total_width(S_COUNT, DATA_WIDTH);

    logic all_valid;
    logic room;
    logic accept;

    assign all_valid     = &s_axis_tvalid;
    assign accept        = room & all_valid;
    assign s_axis_tready = {S_COUNT{accept}};

`ifdef GATHER_SKID_EN
    skid_reg #(
        .WIDTH(W)
    ) u_skid (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .in_data  (s_axis_tdata),
        .in_valid (all_valid),
        .in_ready (room),
        .out_data (m_axis_tdata),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );
`else
    logic         active_q;
    logic         valid_q;
    logic [W-1:0] data_q;

    // active_q keeps ready low until the first clock after reset release.
    assign room = active_q & (~valid_q | m_axis_tready);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (accept) begin
                valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (accept) begin
            data_q <= s_axis_tdata;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
`endif

endmodule

// File: tb/tb_gather.sv
// Scoreboard bench for gather (S_COUNT=3, DATA_WIDTH=8); builds with or
// without GATHER_SKID_EN.
module tb_gather;
    import stream_pkg::*;

    localparam int S  = 3;
    localparam int DW = 8;
    localparam int W  = S * DW;
`ifdef GATHER_SKID_EN
    localparam int MAX_BUF = 2;
`else
    localparam int MAX_BUF = 1;
`endif

    logic         ap_clk   = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic [W-1:0] s_tdata  = '0;
    logic [S-1:0] s_tvalid = '0;
    logic [S-1:0] s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int max_buf  = 0;

    logic [W-1:0] sb[$];
    int           out_cyc[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    gather #(
        .S_COUNT   (S),
        .DATA_WIDTH(DW)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: push on input handshake, pop and compare on output handshake.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check_eq("rdy_uniform", 32'((&s_tready) | (~|s_tready)), 32'd1);
            check_eq("rdy_needs_valid", 32'((|s_tready) & ~(&s_tvalid)), 32'd0);
            if (prev_stall) begin
                check_eq("hold_valid", 32'(m_tvalid), 32'd1);
                check_eq("hold_data", 32'(m_tdata), 32'(prev_data));
            end
            if (s_tready[0] && (&s_tvalid)) sb.push_back(s_tdata);
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) check_eq("unexpected_beat", 32'(sb.size()), 32'd1);
                else check_eq("beat_data", 32'(m_tdata), 32'(sb.pop_front()));
                out_cyc.push_back(cyc);
            end
            if (sb.size() > max_buf) max_buf = sb.size();
            prev_stall = m_tvalid & ~m_tready;
            prev_data  = m_tdata;
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // mode 0: ready high, 1: 4-cycle stall at cycles 4..7, 2: random, 3: ready low
    task automatic run_stream(input int n, input int mode, input int seed_base);
        int b = 0;
        int k = 0;
        while (b < n && k < 20 * n + 20) begin
            for (int i = 0; i < S; i++) begin
                if (mode == 2) s_tdata[lane_lsb(i, DW) +: DW] = 8'($urandom);
                else s_tdata[lane_lsb(i, DW) +: DW] = 8'((seed_base + b) * 3 + i);
            end
            s_tvalid = '1;
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = !(k >= 4 && k <= 7);
                2: m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
            @(negedge ap_clk);
            if (s_tready[0]) b++;
            step();
            k++;
        end
        s_tvalid = '0;
        check_eq("stream_accepted", 32'(b), 32'(n));
    endtask

    task automatic drain();
        int k = 0;
        m_tready = 1'b1;
        while ((sb.size() != 0 || m_tvalid) && k < 50) begin
            step();
            k++;
        end
        check_eq("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        s_tvalid = '1;
        #12;
        check_eq("rst_mvalid", 32'(m_tvalid), 32'd0);
        check_eq("rst_tready", 32'(s_tready), 32'd0);
        s_tvalid = '0;
        @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;
        repeat (3) step();

        // Lane skew: ready only once the last lane turns valid.
        m_tready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin s_tdata[7:0]   = 8'h11; s_tvalid[0] = 1'b1; end
            if (c == 2) begin s_tdata[15:8]  = 8'h22; s_tvalid[1] = 1'b1; end
            if (c == 5) begin s_tdata[23:16] = 8'h33; s_tvalid[2] = 1'b1; end
            @(negedge ap_clk);
            if (c < 5) check_eq("skew_rdy_low", 32'(s_tready), 32'd0);
            else if (c == 5) check_eq("skew_rdy_high", 32'(s_tready), 32'h7);
            else begin
                check_eq("skew_out_valid", 32'(m_tvalid), 32'd1);
                check_eq("skew_out_data", 32'(m_tdata), 32'h332211);
            end
            step();
            if (c == 5) s_tvalid = '0;
        end
        drain();

        // Streaming: 16 beats, 16 consecutive output cycles.
        out_cyc.delete();
        run_stream(16, 0, 0);
        drain();
        check_eq("stream_count", 32'(out_cyc.size()), 32'd16);
        if (out_cyc.size() == 16) check_eq("stream_span", 32'(out_cyc[15] - out_cyc[0]), 32'd15);

        // Backpressure: 4-cycle stall mid-stream.
        max_buf = 0;
        run_stream(12, 1, 40);
        drain();
        check_eq("bp_max_buf", 32'(max_buf), 32'(MAX_BUF));

        // Random stalls.
        run_stream(1000, 2, 0);
        drain();

        // Reset with a beat buffered.
        run_stream(1, 3, 90);
        @(negedge ap_clk);
        check_eq("rst_buffered", 32'(m_tvalid), 32'd1);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        s_tvalid = '1;
        #1;
        check_eq("mid_rst_mvalid", 32'(m_tvalid), 32'd0);
        check_eq("mid_rst_tready", 32'(s_tready), 32'd0);
        sb.delete();
        repeat (2) @(posedge ap_clk);
        s_tvalid = '0;
        #2 ap_rst_n = 1'b1;
        m_tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            check_eq("post_rst_idle", 32'(m_tvalid), 32'd0);
        end
        step();
        run_stream(4, 0, 60);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gather.md
GATHER -- requirements
Module: gather

Interface
REQ-001 SHALL have parameter S_COUNT, default 2, number of AXI-Stream inputs (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each input lane in bits.
REQ-003 SHALL have port ap_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port s_axis_tdata  input  S_COUNT*DATA_WIDTH  input lanes; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port s_axis_tvalid  input  S_COUNT  per-lane valid.
REQ-007 SHALL have port s_axis_tready  output  S_COUNT  per-lane ready.
REQ-008 SHALL have port m_axis_tdata  output  S_COUNT*DATA_WIDTH  gathered beat, with the same lane order as the input.
REQ-009 SHALL have port m_axis_tvalid  output  1  output valid.
REQ-010 SHALL have port m_axis_tready  input  1  output ready.

Function
REQ-011 SHALL accept a beat only when every s_axis_tvalid bit is 1 and the block has room.
- On acceptance, all lanes transfer in the same cycle.
- No lane is ever consumed alone.
REQ-012 SHALL drive every s_axis_tready bit to the identical value: room AND (AND-reduction of s_axis_tvalid).
REQ-013 SHALL keep s_axis_tready low on all lanes while any lane is invalid, even if the other lanes have been valid for many cycles.
REQ-014 SHALL present the accepted beat on m_axis_tdata with m_axis_tvalid=1 exactly one cycle after acceptance when the output register is empty.
REQ-015 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 SHALL sustain one beat per cycle when all inputs are valid and m_axis_tready stays high.
REQ-017 SHALL preserve beat order, with no loss and no duplication, under any pattern of m_axis_tready.
REQ-018 SHALL handle simultaneous output transfer and input acceptance in the same cycle as a pass-through: the output register is reloaded and m_axis_tvalid stays 1.

Reset
REQ-019 SHALL, while ap_rst_n=0, force m_axis_tvalid=0, all s_axis_tready bits=0 and all internal valid flags=0, independent of ap_clk.
REQ-020 SHALL discard any buffered beat when reset is asserted mid-operation; no beat is emitted after release unless it is newly accepted.
REQ-021 SHALL leave the data registers unreset; their values are don't-care while the matching valid flag is 0.
REQ-022 SHALL deassert reset synchronously to ap_clk; the first acceptance is possible no earlier than the first rising edge after release.

Configuration
REQ-023 SHALL use macro GATHER_SKID_EN to select the buffering style.
REQ-024 SHALL, with GATHER_SKID_EN defined, implement a registered room signal plus a one-entry temp register (skid):
- room is a flop loaded each cycle with: (output empty or output transferring) OR (temp empty AND (output empty OR not all inputs valid)).
- A beat accepted while the output is stalled goes to temp.
- When the output transfers, temp moves to output.
- There is no combinational path from m_axis_tready to s_axis_tready.
REQ-025 SHALL, without GATHER_SKID_EN, implement a single output register:
- room = !m_axis_tvalid || m_axis_tready, computed combinationally.
- Latency and throughput are the same as in REQ-014 and REQ-016.

Structure
REQ-026 SHALL place the lane-slicing helper function and the total-width localparam pattern in shared package stream_pkg.
REQ-027 SHALL implement the skid buffering of REQ-024 in one sub-module, skid_reg (parameter WIDTH), instantiated once with WIDTH=S_COUNT*DATA_WIDTH.
- The sub-module is omitted when GATHER_SKID_EN is undefined.

Verification
REQ-028 SHALL cover lane skew. Setup: S_COUNT=3, DW=8. Stimulus: lane0=0x11 valid at cycle 0, lane1=0x22 valid at cycle 2, lane2=0x33 valid at cycle 5, m_ready=1. Required response: all tready rise only at cycle 5, and m_tdata=0x332211 with tvalid=1 at cycle 6.
REQ-029 SHALL cover streaming. Stimulus: 16 beats with lane i = beat*3+i, all valid every cycle, m_ready=1. Required response: 16 output beats in 16 consecutive cycles, in order.
REQ-030 SHALL cover backpressure. Stimulus: m_ready=0 for 4 cycles during streaming. Required response: m_tdata is held stable, at most 2 beats are buffered with skid (1 without), and there is no loss after m_ready returns to 1.
REQ-031 SHALL cover random stalls. Stimulus: random m_ready at 50% over 1000 beats. Required response: the scoreboard matches exactly, and the tready bits are always equal to each other.
REQ-032 SHALL cover reset mid-operation. Stimulus: assert ap_rst_n=0 asynchronously with one beat buffered. Required response: m_tvalid=0 within the same cycle, and the stale beat is never emitted.
REQ-033 SHALL run the full bench in both configurations, with GATHER_SKID_EN defined and undefined.
